// File: rtl/fir_delay_line_if.sv
// Bus bundle for fir_delay_line: sample input, flush, tap read port and eviction output.
// Macro SYMM_PAIR_EN adds the symmetric-pair read outputs rd_data_m and rd_sum.
interface fir_delay_line_if #(
    parameter int DATA_W   = 20,
    parameter int TAPS     = 8,
    parameter int CHANNELS = 2
);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ADDR_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CNT_W  = $clog2(TAPS + 1);

    logic                       din_valid;
    logic [CHANNELS*DATA_W-1:0] DIN;
    logic                       flush;
    logic                       rd_en;
    logic [CH_W-1:0]            rd_ch;
    logic [ADDR_W-1:0]          rd_addr;
    logic [DATA_W-1:0]          rd_data;
    logic                       rd_valid;
    logic                       rd_err;
    logic [CHANNELS*DATA_W-1:0] OUT;
    logic                       out_valid;
    logic [CNT_W-1:0]           fill;
    logic                       full;
`ifdef SYMM_PAIR_EN
    logic [DATA_W-1:0]          rd_data_m;
    logic [DATA_W:0]            rd_sum;
`endif

    modport master (
        output din_valid, DIN, flush, rd_en, rd_ch, rd_addr,
        input  rd_data, rd_valid, rd_err, OUT, out_valid, fill, full
`ifdef SYMM_PAIR_EN
        , rd_data_m, rd_sum
`endif
    );

    modport slave (
        input  din_valid, DIN, flush, rd_en, rd_ch, rd_addr,
        output rd_data, rd_valid, rd_err, OUT, out_valid, fill, full
`ifdef SYMM_PAIR_EN
        , rd_data_m, rd_sum
`endif
    );
endinterface

// File: rtl/fir_delay_line.sv
// Multi-channel sample delay line with registered random tap read and eviction output.
// Macro SYMM_PAIR_EN adds the mirror-tap read and symmetric pre-adder sum.
module fir_delay_line #(
    parameter int DATA_W   = 20,
    parameter int TAPS     = 8,
    parameter int CHANNELS = 2
) (
    input  logic               clk_muestreo,
    input  logic               reset,
    fir_delay_line_if.slave    bus
);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ADDR_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CNT_W  = $clog2(TAPS + 1);

    logic [DATA_W-1:0] taps   [CHANNELS][TAPS];
    logic [DATA_W-1:0] din_ch [CHANNELS];
    logic [DATA_W-1:0] out_q  [CHANNELS];
    logic [CNT_W-1:0]  fill_q;
    logic              full_w;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              rd_err_q;
    logic              out_valid_q;
    logic              rd_oor;
    logic [DATA_W-1:0] sel;
`ifdef SYMM_PAIR_EN
    logic [DATA_W-1:0] sel_m;
    logic [DATA_W-1:0] rd_data_m_q;
    logic [DATA_W:0]   rd_sum_q;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign din_ch[g]                        = bus.DIN[g*DATA_W +: DATA_W];
        assign bus.OUT[g*DATA_W +: DATA_W]      = out_q[g];
    end

    assign full_w = (fill_q == CNT_W'(TAPS));

    always_comb begin
        rd_oor = (32'(bus.rd_addr) >= TAPS) || (32'(bus.rd_ch) >= CHANNELS);
    end

    // Taps at index >= fill are masked to zero independently of their stored contents.
    always_comb begin
        sel = '0;
`ifdef SYMM_PAIR_EN
        sel_m = '0;
`endif
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                if (bus.rd_ch == CH_W'(c) && bus.rd_addr == ADDR_W'(k)) begin
                    if (k < 32'(fill_q))
                        sel = taps[CH_W'(c)][ADDR_W'(k)];
`ifdef SYMM_PAIR_EN
                    if ((TAPS - 1 - k) < 32'(fill_q))
                        sel_m = taps[CH_W'(c)][ADDR_W'(TAPS - 1 - k)];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_muestreo) begin
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                out_q[CH_W'(c)] <= '0;
                for (int unsigned k = 0; k < TAPS; k++)
                    taps[CH_W'(c)][ADDR_W'(k)] <= '0;
            end
            fill_q      <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SYMM_PAIR_EN
            rd_data_m_q <= '0;
            rd_sum_q    <= '0;
`endif
        end else begin
            rd_valid_q  <= bus.rd_en;
            rd_err_q    <= bus.rd_en & rd_oor;
            out_valid_q <= 1'b0;
            if (bus.rd_en) begin
                rd_data_q <= rd_oor ? '0 : sel;
`ifdef SYMM_PAIR_EN
                rd_data_m_q <= rd_oor ? '0 : sel_m;
                rd_sum_q    <= rd_oor ? '0 : ({sel[DATA_W-1], sel} + {sel_m[DATA_W-1], sel_m});
`endif
            end
            // Flush clears first; a same-cycle sample then lands in tap 0 without eviction.
            if (bus.flush) begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    for (int unsigned k = 0; k < TAPS; k++)
                        taps[CH_W'(c)][ADDR_W'(k)] <= '0;
                    if (bus.din_valid)
                        taps[CH_W'(c)][ADDR_W'(0)] <= din_ch[CH_W'(c)];
                end
                fill_q <= bus.din_valid ? CNT_W'(1) : '0;
            end else if (bus.din_valid) begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    taps[CH_W'(c)][ADDR_W'(0)] <= din_ch[CH_W'(c)];
                    for (int unsigned k = 1; k < TAPS; k++)
                        taps[CH_W'(c)][ADDR_W'(k)] <= taps[CH_W'(c)][ADDR_W'(k - 1)];
                    if (full_w)
                        out_q[CH_W'(c)] <= taps[CH_W'(c)][ADDR_W'(TAPS - 1)];
                end
                if (full_w)
                    out_valid_q <= 1'b1;
                else
                    fill_q <= fill_q + CNT_W'(1);
            end
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_err    = rd_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.fill      = fill_q;
    assign bus.full      = full_w;
`ifdef SYMM_PAIR_EN
    assign bus.rd_data_m = rd_data_m_q;
    assign bus.rd_sum    = rd_sum_q;
`endif
endmodule

// File: tb/tb_fir_delay_line.sv
// Scoreboard bench for fir_delay_line: queue-based history model, decoupled read/eviction monitor.
// Also exercises a small 3-channel, 5-tap instance for out-of-range reads.
module tb_fir_delay_line;
    localparam int DW   = 20;
    localparam int TP   = 8;
    localparam int CH   = 2;
    localparam int CH_W = 1;
    localparam int AW   = 3;

    localparam int DW2  = 8;
    localparam int TP2  = 5;
    localparam int CH2  = 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          err;
        logic [DW-1:0] m;
        logic [DW:0]   s;
    } rd_exp_t;

    logic clk = 1'b0;
    logic reset;
    logic reset2;
    always #5 clk = ~clk;

    fir_delay_line_if #(.DATA_W(DW), .TAPS(TP), .CHANNELS(CH)) bus ();
    fir_delay_line_if #(.DATA_W(DW2), .TAPS(TP2), .CHANNELS(CH2)) bus2 ();

    fir_delay_line #(.DATA_W(DW), .TAPS(TP), .CHANNELS(CH)) dut (
        .clk_muestreo(clk),
        .reset(reset),
        .bus(bus)
    );

    fir_delay_line #(.DATA_W(DW2), .TAPS(TP2), .CHANNELS(CH2)) dut2 (
        .clk_muestreo(clk),
        .reset(reset2),
        .bus(bus2)
    );

    // Model: one queue entry per accepted sample word, newest at the front.
    logic [CH*DW-1:0] hist[$];
    rd_exp_t          exp_rd[$];
    logic [CH*DW-1:0] exp_out[$];
    int               tests = 0;
    int               fails = 0;

    function automatic logic [DW-1:0] tap_of(input int c, input int idx);
        logic [CH*DW-1:0] w;
        if (idx < hist.size()) begin
            w = hist[idx];
            return w[c*DW +: DW];
        end
        return '0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit dv, input bit fl, input bit re,
                         input int ch, input int addr, input logic [CH*DW-1:0] din);
        rd_exp_t          e;
        bit               have_rd = 0;
        bit               have_ev = 0;
        logic [CH*DW-1:0] ev = '0;
        int               sd, sm;
        reset         = rst;
        bus.din_valid = dv;
        bus.flush     = fl;
        bus.rd_en     = re;
        bus.rd_ch     = CH_W'(ch);
        bus.rd_addr   = AW'(addr);
        bus.DIN       = din;
        if (rst) begin
            hist.delete();
        end else begin
            if (re) begin
                have_rd = 1;
                e.err = (ch >= CH) || (addr >= TP);
                e.d   = e.err ? '0 : tap_of(ch, addr);
                e.m   = e.err ? '0 : tap_of(ch, TP - 1 - addr);
                sd    = $signed(e.d);
                sm    = $signed(e.m);
                e.s   = (DW+1)'(sd + sm);
            end
            if (fl) begin
                hist.delete();
                if (dv) hist.push_front(din);
            end else if (dv) begin
                hist.push_front(din);
                if (hist.size() > TP) begin
                    ev = hist.pop_back();
                    have_ev = 1;
                end
            end
        end
        @(posedge clk);
        if (have_rd) exp_rd.push_back(e);
        if (have_ev) exp_out.push_back(ev);
        #1;
        chk("fill", 64'(bus.fill), 64'(hist.size()));
        chk("full", 64'(bus.full), 64'(hist.size() == TP));
        if (rst)
            chk("reset_state", {bus.rd_data, bus.OUT[3:0], bus.rd_valid, bus.rd_err, bus.out_valid}, '0);
    endtask

    task automatic push(input int a, input int b);
        drive(0, 1, 0, 0, 0, 0, {DW'(b), DW'(a)});
    endtask

    task automatic rd(input int ch, input int addr);
        drive(0, 0, 0, 1, ch, addr, '0);
    endtask

    rd_exp_t          me;
    logic [CH*DW-1:0] mo;
    bit               ok;

    always @(negedge clk) begin
        if (bus.rd_valid) begin
            tests++;
            if (exp_rd.size() == 0) begin
                fails++;
                $display("FAIL rd_unexpected: rd_valid=1 with no read pending, rd_data=%0h", bus.rd_data);
            end else begin
                me = exp_rd.pop_front();
                ok = (bus.rd_data === me.d) && (bus.rd_err === me.err);
`ifdef SYMM_PAIR_EN
                ok = ok && (bus.rd_data_m === me.m) && (bus.rd_sum === me.s);
                if (!ok) $display("FAIL rd_symm: got m=%0h sum=%0h expected m=%0h sum=%0h",
                                  bus.rd_data_m, bus.rd_sum, me.m, me.s);
`endif
                if (!ok) begin
                    fails++;
                    $display("FAIL rd_data: got data=%0h err=%0b expected data=%0h err=%0b",
                             bus.rd_data, bus.rd_err, me.d, me.err);
                end
            end
        end else if (exp_rd.size() != 0) begin
            tests++;
            fails++;
            me = exp_rd.pop_front();
            $display("FAIL rd_missing: rd_valid=0 expected 1 with data=%0h", me.d);
        end
        if (bus.out_valid) begin
            tests++;
            if (exp_out.size() == 0) begin
                fails++;
                $display("FAIL out_unexpected: out_valid=1 with no eviction, OUT=%0h", bus.OUT);
            end else begin
                mo = exp_out.pop_front();
                if (bus.OUT !== mo) begin
                    fails++;
                    $display("FAIL out_data: got %0h expected %0h", bus.OUT, mo);
                end
            end
        end else if (exp_out.size() != 0) begin
            tests++;
            fails++;
            mo = exp_out.pop_front();
            $display("FAIL out_missing: out_valid=0 expected 1 with OUT=%0h", mo);
        end
    end

    initial begin
        bus.din_valid = 0; bus.flush = 0; bus.rd_en = 0; bus.rd_ch = '0; bus.rd_addr = '0; bus.DIN = '0;
        bus2.din_valid = 0; bus2.flush = 0; bus2.rd_en = 0; bus2.rd_ch = '0; bus2.rd_addr = '0; bus2.DIN = '0;
        reset  = 1;
        reset2 = 1;

        drive(1, 0, 0, 0, 0, 0, '0);
        drive(1, 1, 0, 1, 0, 0, '1);

        // Fill 1..8 / 101..108, reads including symmetric pair addr1, then one eviction.
        for (int i = 1; i <= 8; i++) push(i, 100 + i);
        rd(0, 0);
        rd(1, 7);
        rd(0, 1);
        push(9, 109);
        rd(0, 0);
        rd(0, 7);

        // Partial history: unfilled taps read as zero.
        drive(1, 0, 0, 0, 0, 0, '0);
        push(5, 55);
        push(6, 66);
        push(7, 77);
        rd(0, 3);
        rd(0, 0);
        rd(1, 2);

        // Read and shift in the same cycle returns pre-shift contents.
        drive(0, 1, 0, 1, 0, 0, {DW'(3), 20'hFFFFF});
        rd(0, 0);

        // Flush while full, with and without same-cycle sample/read.
        for (int i = 0; i < 6; i++) push(200 + i, 300 + i);
        drive(0, 1, 1, 1, 0, 7, {DW'(43), DW'(42)});
        rd(0, 0);
        rd(0, 1);
        push(1, 2);
        drive(0, 0, 1, 1, 1, 0, '0);
        rd(1, 0);

        // Extreme negative pair for the pre-adder.
        drive(1, 0, 0, 0, 0, 0, '0);
        push(20'h80000, 20'h7FFFF);
        for (int i = 0; i < 6; i++) push(i, i);
        push(20'hFFFFF, 20'h7FFFF);
        rd(0, 0);
        rd(1, 7);

        // Random traffic with occasional flush and mid-stream reset.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 99);
            drive(r < 2, $urandom_range(0, 2) != 0, (r >= 2 && r < 6), $urandom_range(0, 1) == 1,
                  $urandom_range(0, CH - 1), $urandom_range(0, TP - 1), {DW'($urandom), DW'($urandom)});
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, '0);
        chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
        chk("out_queue_drained", 64'(exp_out.size()), 64'd0);

        // Second instance: 3 channels, 5 taps, so out-of-range channel and address are reachable.
        @(posedge clk); #1;
        reset2 = 0;
        for (int i = 1; i <= 3; i++) begin
            bus2.din_valid = 1;
            bus2.DIN = {DW2'(30 + i), DW2'(20 + i), DW2'(10 + i)};
            @(posedge clk); #1;
        end
        bus2.din_valid = 0;
        chk("i2_fill", 64'(bus2.fill), 64'd3);
        bus2.rd_en = 1;
        bus2.rd_ch = 2'd3; bus2.rd_addr = 3'd0;
        @(posedge clk); #1;
        chk("i2_bad_ch", {bus2.rd_valid, bus2.rd_err, bus2.rd_data}, {1'b1, 1'b1, 8'd0});
        bus2.rd_ch = 2'd2; bus2.rd_addr = 3'd0;
        @(posedge clk); #1;
        chk("i2_ch2_a0", {bus2.rd_valid, bus2.rd_err, bus2.rd_data}, {1'b1, 1'b0, 8'd33});
        bus2.rd_ch = 2'd0; bus2.rd_addr = 3'd5;
        @(posedge clk); #1;
        chk("i2_bad_addr", {bus2.rd_valid, bus2.rd_err, bus2.rd_data}, {1'b1, 1'b1, 8'd0});
        bus2.rd_ch = 2'd0; bus2.rd_addr = 3'd4;
        @(posedge clk); #1;
        chk("i2_unfilled", {bus2.rd_valid, bus2.rd_err, bus2.rd_data}, {1'b1, 1'b0, 8'd0});
        bus2.rd_ch = 2'd1; bus2.rd_addr = 3'd2;
        @(posedge clk); #1;
        chk("i2_ch1_a2", {bus2.rd_valid, bus2.rd_err, bus2.rd_data}, {1'b1, 1'b0, 8'd21});
        bus2.rd_en = 0;
        @(posedge clk); #1;
        chk("i2_idle", {bus2.rd_valid, bus2.rd_err}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
